pipeline_ctrl: RTL and testbench

Central sequencing unit for the five-stage ARM-subset pipeline. Each cycle it resolves the instruction-fetch stage's freeze/branch controls and the downstream stage enables/flushes from three sources: the ID-stage data-hazard flag, the EX-stage branch decision and the MEM-stage memory handshake. It owns the memory-wait state machine with a timeout trap, and keeps saturating stall/flush counters for performance debug.

---
 rtl/pipeline_ctrl_if.sv | 31 +++
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the stage controls.
// master = pipeline datapath side, slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_if;
  logic             freeze_id;
  logic             bubble_ex;
  logic             flush_if_id;
  logic             freeze_pipe;
  logic             mem_err;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hazard, branch_taken, mem_req, mem_ready,
    input  freeze_if, freeze_id, bubble_ex, flush_if_id, freeze_pipe,
           mem_err, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  hazard, branch_taken, mem_req, mem_ready,
    output freeze_if, freeze_id, bubble_ex, flush_if_id, freeze_pipe,
           mem_err, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: resolves freeze/bubble/flush controls from
// hazard, branch and memory handshake, with a memory-wait timeout trap.
module pipeline_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze_if, freeze_id, bubble_ex, flush_if_id, freeze_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    freeze_if   = 1'b0;
    freeze_id   = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    freeze_pipe = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        wait_d = '0;
        if (bus.mem_req && !bus.mem_ready) begin
          freeze_if   = 1'b1;
          freeze_id   = 1'b1;
          freeze_pipe = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_d      = 8'd1;
        end else if (bus.branch_taken) begin
          // a concurrent hazard belongs to the instruction being flushed
          flush_if_id = 1'b1;
          bubble_ex   = 1'b1;
          if (flush_q != '1) flush_d = flush_q + CNT_ONE;
        end else if (bus.hazard) begin
          freeze_if = 1'b1;
          freeze_id = 1'b1;
          bubble_ex = 1'b1;
          if (stall_q != '1) stall_d = stall_q + CNT_ONE;
        end
      end

      ST_MEM_WAIT: begin
        // EX is frozen here, so branch/hazard re-present after the stall
        freeze_if   = 1'b1;
        freeze_id   = 1'b1;
        freeze_pipe = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_q == TIMEOUT) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_ERR: begin
        freeze_if   = 1'b1;
        freeze_id   = 1'b1;
        freeze_pipe = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.freeze_if   = freeze_if;
  assign bus.freeze_id   = freeze_id;
  assign bus.bubble_ex   = bubble_ex;
  assign bus.flush_if_id = flush_if_id;
  assign bus.freeze_pipe = freeze_pipe;
  assign bus.mem_err     = (state_q == ST_ERR);
  assign bus.ctrl_state  = state_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl; a second narrow-counter
// instance covers counter saturation.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_ctrl_if #(.CNT_W(2))  bus2 ();

  pipeline_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_ctrl #(.CNT_W(2), .MEM_TIMEOUT(15)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // {freeze_if, freeze_id, bubble_ex, flush_if_id, freeze_pipe, mem_err}
  logic [5:0] ctl;
  logic [5:0] ctl2;
  assign ctl  = {bus.freeze_if, bus.freeze_id, bus.bubble_ex,
                 bus.flush_if_id, bus.freeze_pipe, bus.mem_err};
  assign ctl2 = {bus2.freeze_if, bus2.freeze_id, bus2.bubble_ex,
                 bus2.flush_if_id, bus2.freeze_pipe, bus2.mem_err};

  typedef struct packed {
    logic [3:0]  in;     // {hazard, branch_taken, mem_req, mem_ready}
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
  } vec_t;

  localparam int unsigned NVEC = 20;
  vec_t vec [NVEC];

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] in);
    {bus.hazard, bus.branch_taken, bus.mem_req, bus.mem_ready} = in;
  endtask

  // advance one cycle: inputs applied 1ns after the edge, sampled 1ns later
  task automatic step(input logic [3:0] in);
    @(posedge clk);
    #1 drive(in);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [5:0] c, input logic [1:0] s,
                         input logic [15:0] sc, input logic [15:0] fc);
    chk({tag, " ctl"},   32'(ctl), 32'(c));
    chk({tag, " state"}, 32'(bus.ctrl_state), 32'(s));
    chk({tag, " stall"}, 32'(bus.stall_cnt), 32'(sc));
    chk({tag, " flush"}, 32'(bus.flush_cnt), 32'(fc));
  endtask

  initial begin
    // idle, hazard stalls, hazard+branch, concurrent mem, mem stall w/ branch held
    vec[0]  = '{4'b0000, 6'b000000, 2'b00, 16'd0, 16'd0};
    vec[1]  = '{4'b0000, 6'b000000, 2'b00, 16'd0, 16'd0};
    vec[2]  = '{4'b0000, 6'b000000, 2'b00, 16'd0, 16'd0};
    vec[3]  = '{4'b0000, 6'b000000, 2'b00, 16'd0, 16'd0};
    vec[4]  = '{4'b0000, 6'b000000, 2'b00, 16'd0, 16'd0};
    vec[5]  = '{4'b1000, 6'b111000, 2'b00, 16'd0, 16'd0};
    vec[6]  = '{4'b1000, 6'b111000, 2'b00, 16'd1, 16'd0};
    vec[7]  = '{4'b1000, 6'b111000, 2'b00, 16'd2, 16'd0};
    vec[8]  = '{4'b0000, 6'b000000, 2'b00, 16'd3, 16'd0};
    vec[9]  = '{4'b1100, 6'b001100, 2'b00, 16'd3, 16'd0};
    vec[10] = '{4'b0000, 6'b000000, 2'b00, 16'd3, 16'd1};
    vec[11] = '{4'b0011, 6'b000000, 2'b00, 16'd3, 16'd1};
    vec[12] = '{4'b0000, 6'b000000, 2'b00, 16'd3, 16'd1};
    vec[13] = '{4'b0110, 6'b110010, 2'b00, 16'd3, 16'd1};
    vec[14] = '{4'b0110, 6'b110010, 2'b01, 16'd3, 16'd1};
    vec[15] = '{4'b1110, 6'b110010, 2'b01, 16'd3, 16'd1};
    vec[16] = '{4'b0110, 6'b110010, 2'b01, 16'd3, 16'd1};
    vec[17] = '{4'b0111, 6'b110010, 2'b01, 16'd3, 16'd1};
    vec[18] = '{4'b0100, 6'b001100, 2'b00, 16'd3, 16'd1};
    vec[19] = '{4'b0000, 6'b000000, 2'b00, 16'd3, 16'd2};

    drive(4'b0000);
    bus2.hazard = 1'b0; bus2.branch_taken = 1'b0;
    bus2.mem_req = 1'b0; bus2.mem_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 6'b000000, 2'b00, 16'd0, 16'd0);
    chk("reset sat ctl", 32'(ctl2), 32'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      step(vec[i].in);
      chk_all($sformatf("vec%0d", i), vec[i].ctl, vec[i].st, vec[i].stall, vec[i].flush);
    end

    // timeout: RUN on cycle 1, MEM_WAIT cycles 2..16, ERR from 17
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step(4'b0010);
      if (cyc == 1)
        chk_all($sformatf("tmo%0d", cyc), 6'b110010, 2'b00, 16'd3, 16'd2);
      else if (cyc <= 16)
        chk_all($sformatf("tmo%0d", cyc), 6'b110010, 2'b01, 16'd3, 16'd2);
      else
        chk_all($sformatf("tmo%0d", cyc), 6'b110011, 2'b10, 16'd3, 16'd2);
    end

    // asynchronous reset out of ERR
    @(posedge clk);
    #1 drive(4'b0000);
    rst = 1'b0;
    #1 chk_all("err_rst", 6'b000000, 2'b00, 16'd0, 16'd0);
    @(negedge clk) rst = 1'b1;
    step(4'b0000);
    chk_all("post_err_rst", 6'b000000, 2'b00, 16'd0, 16'd0);

    // reset in the middle of MEM_WAIT
    step(4'b0010);
    step(4'b0010);
    chk("midwait state", 32'(bus.ctrl_state), 32'd1);
    #1 drive(4'b0000);
    rst = 1'b0;
    #1 chk_all("midwait_rst", 6'b000000, 2'b00, 16'd0, 16'd0);
    @(negedge clk) rst = 1'b1;
    step(4'b0000);
    chk_all("post_midwait", 6'b000000, 2'b00, 16'd0, 16'd0);

    // 2-bit stall counter saturates at 3
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 bus2.hazard = 1'b1;
      #1;
      chk($sformatf("sat%0d ctl", k), 32'(ctl2), 32'(6'b111000));
      chk($sformatf("sat%0d cnt", k), 32'(bus2.stall_cnt), (k < 3) ? k : 3);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 bus2.hazard = 1'b0;
      #1 chk($sformatf("sat_hold%0d", k), 32'(bus2.stall_cnt), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
